// File: rtl/dram_impctl_pkg.sv
// Shared types and constants for the DRAM pad impedance calibration controller.
package dram_impctl_pkg;

  localparam int CODE_W = 8;
  localparam logic [CODE_W-1:0] CODE_MIN = 8'h00;
  localparam logic [CODE_W-1:0] CODE_MAX = 8'hFF;
  localparam logic [CODE_W-1:0] CODE_RST = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PU_SETTLE,
    ST_PU_SAMPLE,
    ST_PD_SETTLE,
    ST_PD_SAMPLE,
    ST_WAIT_UPD
  } impctl_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } step_dir_t;

endpackage

// File: rtl/dram_pad_impctl_if.sv
// Calibration request/commit bundle between the DRAM controller, replica leg and pad ring.
interface dram_pad_impctl_if;
  import dram_impctl_pkg::*;

  // cal_req is a one-cycle pulse, accepted only while cal_busy is low; upd_allow is a
  // level grant and a commit happens in the first cycle it is high while results wait.
  logic              cal_req;
  logic              upd_allow;
  logic              cmp_out;
  logic              cal_pu_sel;
  logic [CODE_W-1:0] cal_code;
  logic [8:1]        cbu;
  logic [8:1]        cbd;
  logic              cal_busy;
  logic              cal_done;
  logic              cal_err;
  impctl_state_t     dbg_state;

  modport master (
    input  cal_req, upd_allow, cmp_out,
    output cal_pu_sel, cal_code, cbu, cbd, cal_busy, cal_done, cal_err, dbg_state
  );

  modport slave (
    output cal_req, upd_allow, cmp_out,
    input  cal_pu_sel, cal_code, cbu, cbd, cal_busy, cal_done, cal_err, dbg_state
  );

endinterface

// File: rtl/dram_impctl_leg_search.sv
// Single-step up/down code search shared by the pull-up and pull-down legs; converges on
// the second direction reversal, aborts on saturation or iteration overflow.
module dram_impctl_leg_search
  import dram_impctl_pkg::*;
#(
  parameter int                MAX_ITER = 64,
  parameter logic [CODE_W-1:0] RST_CODE = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CODE_W-1:0] load_code,
  input  logic              step,
  input  logic              step_up,
  output logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] code_next,
  output logic              converged,
  output logic              abort
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);

  step_dir_t         dir_q;
  step_dir_t         dir_now;
  logic [1:0]        rev_q;
  logic [ITER_W-1:0] iter_q;
  logic              saturate;
  logic              reversal;

  always_comb begin
    dir_now   = step_up ? DIR_UP : DIR_DN;
    saturate  = step_up ? (code == CODE_MAX) : (code == CODE_MIN);
    code_next = step_up ? (code + 1'b1) : (code - 1'b1);
    reversal  = (dir_q != DIR_NONE) && (dir_q != dir_now);
    converged = step && !saturate && reversal && (rev_q == 2'd1);
    // Convergence on the final permitted step wins over the iteration limit.
    abort     = step && (saturate ||
                         (!converged && ((iter_q + 1'b1) == ITER_W'(MAX_ITER))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code   <= RST_CODE;
      dir_q  <= DIR_NONE;
      rev_q  <= 2'd0;
      iter_q <= '0;
    end else if (load) begin
      code   <= load_code;
      dir_q  <= DIR_NONE;
      rev_q  <= 2'd0;
      iter_q <= '0;
    end else if (step && !saturate) begin
      code   <= code_next;
      dir_q  <= dir_now;
      iter_q <= iter_q + 1'b1;
      if (reversal && (rev_q != 2'd2)) rev_q <= rev_q + 1'b1;
    end
  end

endmodule

// File: rtl/dram_pad_impctl.sv
// DRAM SSTL pad impedance calibration: pull-up then pull-down search, committed in an idle window.
// Optional periodic auto-calibration is enabled by defining DRAM_IMPCTL_PERIODIC_EN.
module dram_pad_impctl
  import dram_impctl_pkg::*;
#(
  parameter int                SETTLE_CYC = 8,
  parameter int                MAX_ITER   = 64,
  parameter logic [CODE_W-1:0] CODE_RST   = 8'h80
`ifdef DRAM_IMPCTL_PERIODIC_EN
  ,
  parameter int                PERIOD     = 1 << 20
`endif
) (
  input logic               clk,
  input logic               rst,
  dram_pad_impctl_if.master bus
);

  localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  impctl_state_t     state_q;
  impctl_state_t     state_d;
  logic [SETTLE_W-1:0] settle_q;
  logic              settle_done;
  logic [CODE_W-1:0] pu_w;
  logic [CODE_W-1:0] pd_w;
  logic [CODE_W-1:0] cbu_q;
  logic [CODE_W-1:0] cbd_q;
  logic              done_q;
  logic              err_q;
  logic              start;
  logic              commit;
  logic              leg_load;
  logic [CODE_W-1:0] leg_load_code;
  logic              leg_step;
  logic [CODE_W-1:0] leg_code;
  logic [CODE_W-1:0] leg_code_next;
  logic              leg_conv;
  logic              leg_abort;

`ifdef DRAM_IMPCTL_PERIODIC_EN
  localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  logic [PER_W-1:0] per_q;
  logic             per_wrap;

  assign per_wrap = (per_q == PER_W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || per_wrap) per_q <= '0;
    else                 per_q <= per_q + 1'b1;
  end

  // A wrap outside IDLE is simply not acted on by the FSM.
  assign start = bus.cal_req | per_wrap;
`else
  assign start = bus.cal_req;
`endif

  dram_impctl_leg_search #(
    .MAX_ITER (MAX_ITER),
    .RST_CODE (CODE_RST)
  ) u_leg (
    .clk       (clk),
    .rst       (rst),
    .load      (leg_load),
    .load_code (leg_load_code),
    .step      (leg_step),
    .step_up   (bus.cmp_out),
    .code      (leg_code),
    .code_next (leg_code_next),
    .converged (leg_conv),
    .abort     (leg_abort)
  );

  assign settle_done = (settle_q == '0);

  always_comb begin
    state_d       = state_q;
    leg_load      = 1'b0;
    leg_load_code = pu_w;
    leg_step      = 1'b0;
    commit        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_PU_SETTLE;
          leg_load      = 1'b1;
          leg_load_code = pu_w;
        end
      end
      ST_PU_SETTLE: if (settle_done) state_d = ST_PU_SAMPLE;
      ST_PU_SAMPLE: begin
        leg_step = 1'b1;
        if (leg_abort) begin
          state_d       = ST_IDLE;
          leg_load      = 1'b1;
          leg_load_code = cbu_q;
        end else if (leg_conv) begin
          state_d       = ST_PD_SETTLE;
          leg_load      = 1'b1;
          leg_load_code = pd_w;
        end else begin
          state_d = ST_PU_SETTLE;
        end
      end
      ST_PD_SETTLE: if (settle_done) state_d = ST_PD_SAMPLE;
      ST_PD_SAMPLE: begin
        leg_step = 1'b1;
        if (leg_abort) begin
          state_d       = ST_IDLE;
          leg_load      = 1'b1;
          leg_load_code = cbu_q;
        end else if (leg_conv) begin
          state_d = ST_WAIT_UPD;
        end else begin
          state_d = ST_PD_SETTLE;
        end
      end
      ST_WAIT_UPD: begin
        if (bus.upd_allow) begin
          commit        = 1'b1;
          state_d       = ST_IDLE;
          leg_load      = 1'b1;
          leg_load_code = pu_w;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= SETTLE_W'(SETTLE_CYC - 1);
      pu_w     <= CODE_RST;
      pd_w     <= CODE_RST;
      cbu_q    <= CODE_RST;
      cbd_q    <= CODE_RST;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Reloaded in every non-settle state so each settle window is exactly SETTLE_CYC long.
      if ((state_q == ST_PU_SETTLE) || (state_q == ST_PD_SETTLE)) begin
        if (!settle_done) settle_q <= settle_q - 1'b1;
      end else begin
        settle_q <= SETTLE_W'(SETTLE_CYC - 1);
      end
      done_q <= commit;
      if ((state_q == ST_IDLE) && start) err_q <= 1'b0;
      else if (leg_abort)                err_q <= 1'b1;
      if (leg_abort) begin
        pu_w <= cbu_q;
        pd_w <= cbd_q;
      end else if ((state_q == ST_PU_SAMPLE) && leg_conv) begin
        pu_w <= leg_code_next;
      end else if ((state_q == ST_PD_SAMPLE) && leg_conv) begin
        pd_w <= leg_code_next;
      end
      if (commit) begin
        cbu_q <= pu_w;
        cbd_q <= pd_w;
      end
    end
  end

  assign bus.cal_pu_sel = (state_q == ST_IDLE) || (state_q == ST_PU_SETTLE) ||
                          (state_q == ST_PU_SAMPLE);
  assign bus.cal_code   = leg_code;
  assign bus.cbu        = cbu_q;
  assign bus.cbd        = cbd_q;
  assign bus.cal_busy   = (state_q != ST_IDLE);
  assign bus.cal_done   = done_q;
  assign bus.cal_err    = err_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_dram_pad_impctl.sv
// Directed bench for dram_pad_impctl with a behavioural replica comparator.
module tb_dram_pad_impctl;
  import dram_impctl_pkg::*;

  localparam int SETTLE = 2;
  localparam int MAX_IT = 140;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_pad_impctl_if ifc ();

  dram_pad_impctl #(
    .SETTLE_CYC (SETTLE),
    .MAX_ITER   (MAX_IT),
    .CODE_RST   (8'h80)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  // ---------------- comparator model ----------------
  // mode 0: pull-up ref 0x93, pull-down ref 0x6A; mode 1: stuck high;
  // mode 2: step down until code 0x01 is seen, then step up forever.
  int   cmp_mode = 0;
  logic low_seen = 1'b0;

  always_comb begin
    case (cmp_mode)
      1:       ifc.cmp_out = 1'b1;
      2:       ifc.cmp_out = low_seen || (ifc.cal_code == 8'h01);
      default: ifc.cmp_out = ifc.cal_pu_sel ? (ifc.cal_code < 8'h93) : (ifc.cal_code < 8'h6A);
    endcase
  end

  always @(posedge clk) begin
    if (cmp_mode != 2)              low_seen <= 1'b0;
    else if (ifc.cal_code == 8'h01) low_seen <= 1'b1;
  end

  // ---------------- event monitors ----------------
  int done_cnt = 0;
  int busy_cyc = 0;
  always @(posedge clk) begin
    if (ifc.cal_done) done_cnt <= done_cnt + 1;
    if (ifc.cal_busy) busy_cyc <= busy_cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    ifc.cal_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_req();
    ifc.cal_req = 1'b1;
    tick();
    ifc.cal_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (ifc.cal_busy && (cyc < budget)) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_state(input impctl_state_t s, input int budget, output int cyc);
    cyc = 0;
    while ((ifc.dbg_state != s) && (cyc < budget)) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cbu"},    ifc.cbu, 8'h80);
    check_eq({tag, "_cbd"},    ifc.cbd, 8'h80);
    check_eq({tag, "_code"},   ifc.cal_code, 8'h80);
    check_eq({tag, "_pu_sel"}, ifc.cal_pu_sel, 1'b1);
    check_eq({tag, "_busy"},   ifc.cal_busy, 1'b0);
    check_eq({tag, "_done"},   ifc.cal_done, 1'b0);
    check_eq({tag, "_err"},    ifc.cal_err, 1'b0);
    check_eq({tag, "_state"},  ifc.dbg_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int d0;
    int b0;
    ifc.cal_req   = 1'b0;
    ifc.upd_allow = 1'b0;

    do_reset();
    check_reset_outputs("rst0");

    // Full calibration with the idle window withheld for 500 cycles.
    cmp_mode = 0;
    d0 = done_cnt;
    pulse_req();
    check_eq("start_busy",  ifc.cal_busy, 1'b1);
    check_eq("start_state", ifc.dbg_state, ST_PU_SETTLE);
    tick();
    tick();
    check_eq("settle_state", ifc.dbg_state, ST_PU_SAMPLE);
    check_eq("settle_code",  ifc.cal_code, 8'h80);
    tick();
    check_eq("step1_code",  ifc.cal_code, 8'h81);
    check_eq("step1_state", ifc.dbg_state, ST_PU_SETTLE);
    repeat (500) tick();
    check_eq("hold_state", ifc.dbg_state, ST_WAIT_UPD);
    check_eq("hold_busy",  ifc.cal_busy, 1'b1);
    check_eq("hold_cbu",   ifc.cbu, 8'h80);
    check_eq("hold_cbd",   ifc.cbd, 8'h80);
    check_eq("hold_ndone", done_cnt - d0, 0);
    // Commit and a new request land in the same cycle: request must be dropped.
    ifc.upd_allow = 1'b1;
    ifc.cal_req   = 1'b1;
    tick();
    ifc.cal_req = 1'b0;
    check_eq("commit_cbu",   ifc.cbu, 8'h93);
    check_eq("commit_cbd",   ifc.cbd, 8'h69);
    check_eq("commit_done",  ifc.cal_done, 1'b1);
    check_eq("commit_busy",  ifc.cal_busy, 1'b0);
    check_eq("commit_err",   ifc.cal_err, 1'b0);
    tick();
    check_eq("post_done",  ifc.cal_done, 1'b0);
    check_eq("post_busy",  ifc.cal_busy, 1'b0);
    check_eq("post_state", ifc.dbg_state, ST_IDLE);
    check_eq("post_ndone", done_cnt - d0, 1);

    // Tracking run starts from the committed codes and dithers by one.
    d0 = done_cnt;
    pulse_req();
    wait_idle(2000, cyc);
    check_eq("track_idle", ifc.cal_busy, 1'b0);
    check_eq("track_done", ifc.cal_done, 1'b1);
    check_eq("track_cbu",  ifc.cbu, 8'h92);
    check_eq("track_cbd",  ifc.cbd, 8'h6A);
    tick();
    check_eq("track_ndone", done_cnt - d0, 1);

    // Comparator stuck high: pull-up saturates at 0xFF after 127 steps.
    do_reset();
    cmp_mode = 1;
    d0 = done_cnt;
    pulse_req();
    wait_idle(2000, cyc);
    check_eq("sat_cycles", cyc, 384);
    check_eq("sat_err",    ifc.cal_err, 1'b1);
    check_eq("sat_busy",   ifc.cal_busy, 1'b0);
    check_eq("sat_cbu",    ifc.cbu, 8'h80);
    check_eq("sat_cbd",    ifc.cbd, 8'h80);
    check_eq("sat_state",  ifc.dbg_state, ST_IDLE);
    tick();
    check_eq("sat_ndone",  done_cnt - d0, 0);

    // Recovery run with extra requests at cycles 5 and 20 that must be ignored.
    cmp_mode = 0;
    d0 = done_cnt;
    pulse_req();
    check_eq("recov_err_clr", ifc.cal_err, 1'b0);
    for (int t = 1; t <= 21; t++) begin
      ifc.cal_req = (t == 5) || (t == 20);
      tick();
    end
    ifc.cal_req = 1'b0;
    check_eq("extra_code",  ifc.cal_code, 8'h87);
    check_eq("extra_state", ifc.dbg_state, ST_PU_SETTLE);
    wait_idle(2000, cyc);
    check_eq("recov_cbu", ifc.cbu, 8'h93);
    check_eq("recov_cbd", ifc.cbd, 8'h69);
    tick();
    check_eq("recov_ndone", done_cnt - d0, 1);

    // Non-converging search from 0x93 runs into the iteration limit.
    cmp_mode = 2;
    d0 = done_cnt;
    pulse_req();
    wait_idle(2000, cyc);
    check_eq("iter_cycles", cyc, 3 * MAX_IT);
    check_eq("iter_err",    ifc.cal_err, 1'b1);
    check_eq("iter_cbu",    ifc.cbu, 8'h93);
    check_eq("iter_cbd",    ifc.cbd, 8'h69);
    tick();
    check_eq("iter_ndone",  done_cnt - d0, 0);

    // Reset during the pull-down sample, then a clean calibration from reset codes.
    cmp_mode = 0;
    pulse_req();
    wait_state(ST_PD_SAMPLE, 2000, cyc);
    check_eq("pd_reach", ifc.dbg_state, ST_PD_SAMPLE);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    pulse_req();
    wait_idle(2000, cyc);
    check_eq("fresh_cbu", ifc.cbu, 8'h93);
    check_eq("fresh_cbd", ifc.cbd, 8'h69);
    check_eq("fresh_err", ifc.cal_err, 1'b0);

    // No request: no calibration activity over 10000 cycles.
    tick();
    b0 = busy_cyc;
    repeat (10000) tick();
    check_eq("quiet_busy",  busy_cyc - b0, 0);
    check_eq("quiet_state", ifc.dbg_state, ST_IDLE);
    check_eq("quiet_cbu",   ifc.cbu, 8'h93);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_pad_impctl.md
Name: dram_pad_impctl

Overview:
Impedance calibration controller for the DRAM SSTL pad ring; sits directly upstream of each dram_sstl_pad and drives its shared cbu[8:1]/cbd[8:1] drive-strength codes.
- Runs a pull-up search, then a pull-down search, against an off-chip reference resistor via a replica leg and analog comparator.
- Commits new codes to the pads only inside a controller-granted idle window, so drive strength never changes mid-burst.

Parameters:
SETTLE_CYC, 8, cycles to wait after changing replica code before sampling cmp_out (min 1)
MAX_ITER, 64, step limit per leg search before declaring error
CODE_RST, 8'h80, reset/initial value of all codes

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
cal_req  input  1  one-cycle pulse: start a calibration
upd_allow  input  1  DRAM controller idle window; codes may be committed when high
cmp_out  input  1  replica comparator: 1 = replica weaker than reference (step code up)
cal_pu_sel  output  1  1 = replica in pull-up mode, 0 = pull-down mode
cal_code  output  8  code driven onto replica leg
cbu  output  8 [8:1]  committed pull-up code to pads
cbd  output  8 [8:1]  committed pull-down code to pads
cal_busy  output  1  high from accepted cal_req until commit or abort
cal_done  output  1  one-cycle pulse on commit
cal_err  output  1  sticky; set on saturation/iteration overflow, cleared by next accepted cal_req

Behaviour:
- Reset values: cbu=cbd=cal_code=CODE_RST; cal_pu_sel=1; cal_busy=cal_done=cal_err=0; FSM=IDLE; working regs pu_w=pd_w=CODE_RST.
- FSM states: IDLE -> PU_SETTLE -> PU_SAMPLE -> PD_SETTLE -> PD_SAMPLE -> WAIT_UPD -> IDLE.
- IDLE: cal_req=1 -> PU_SETTLE; cal_busy=1 next cycle; cal_err cleared; cal_pu_sel=1; cal_code=pu_w; settle counter loaded.
- x_SETTLE: count SETTLE_CYC cycles, then -> x_SAMPLE.
- x_SAMPLE (one cycle): cmp_out=1 -> code+1, else code-1; iteration count +1; return to x_SETTLE with the new code on cal_code.
- Direction tracking: a step whose direction differs from the previous step counts one reversal.
- Leg converged on the 2nd reversal; the final code is the value after that step. PU converged -> PD_SETTLE with cal_pu_sel=0, cal_code=pd_w.
- Saturation: a step that would go above 8'hFF or below 8'h00 is not taken, and the leg aborts.
- Abort (saturation or iteration count reaching MAX_ITER): cal_err=1; go to IDLE; cal_busy=0; cbu/cbd unchanged; working regs reset to current cbu/cbd.
- WAIT_UPD: wait for upd_allow=1. In that cycle cbu<=pu_w, cbd<=pd_w, cal_done pulses, then IDLE, cal_busy=0. There is no timeout; the block waits indefinitely.
- cbu/cbd change only in the WAIT_UPD commit cycle or on reset.
- cal_req while cal_busy=1: ignored, not queued.
- cal_req and commit in the same cycle: commit completes; the request is ignored.
- rst mid-operation: every output returns to its reset value; nothing partial is committed.
- Subsequent calibrations start each leg search from the last committed code (tracking mode).

Optional Feature:
DRAM_IMPCTL_PERIODIC_EN
- Defined: adds parameter PERIOD (default 2^20) and a free-running counter cleared by rst. Each counter wrap, while in IDLE, acts as an internal cal_req. A wrap while busy is dropped.
- Not defined: counter and parameter are absent; calibration runs only on cal_req.

Decomposition:
- Package dram_impctl_pkg: FSM state enum, CODE_W=8 localparam, CODE_MIN/CODE_MAX/CODE_RST constants, step-direction enum.
- Sub-module dram_impctl_leg_search: holds code register, direction/reversal tracking, iteration counter and saturation check. Instantiated once and time-shared between legs via load/start/converged/abort signals.
- Top level owns settle counter, FSM, commit registers, periodic timer.

Test Plan:
- Reference at 8'h93 (comparator model cmp_out = replica code < 8'h93), pull-down reference at 8'h6A, upd_allow=1 -> cal_done pulses; cbu=8'h93±1, cbd=8'h6A±1; cal_err=0.
- Same run with upd_allow held 0 for 500 cycles, then 1 -> cal_busy stays high; cbu/cbd hold 8'h80 until the commit cycle; cal_done pulses exactly once.
- cmp_out stuck 1 -> pull-up code climbs to 8'hFF then aborts -> cal_err=1, cbu=cbd=8'h80, cal_busy=0, no cal_done.
- Extra cal_req pulses at cycles 5 and 20 of an active calibration -> exactly one cal_done, and no restart is observed.
- rst asserted during PD_SAMPLE -> next cycle all outputs at reset values, FSM=IDLE; a fresh cal_req completes normally.
- With DRAM_IMPCTL_PERIODIC_EN, PERIOD=4096 -> calibration auto-starts at cycle 4096 and 8192; without the macro, no activity over 10000 cycles.
